cnt_gate_ctrl: RTL and testbench

Measurement-window controller that sits directly around the debounced pulse counter.
- Upstream: drives the counter's enable and synchronous-clear inputs to define a gate window of programmable length.
- Downstream: captures the counter value after the window closes and offers it on a valid/ready interface.
- Together with the counter, it forms one channel of a pulse-rate / frequency meter.

---
 rtl/cnt_gate_ctrl_if.sv | 45 ++++
 rtl/cnt_gate_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cnt_gate_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_gate_ctrl_if.sv
// Result interface of the measurement-window controller.
// Carries the captured count, its overflow qualifier and the valid/ready
// handshake. When CNT_GATE_AUTO_RESTART_EN is defined the bus also carries
// the one-cycle "result lost" pulse of the free-running mode.
interface cnt_gate_ctrl_if #(
    parameter int CNT_WIDTH = 8
);
    logic [CNT_WIDTH-1:0] data;
    logic                 ovf;
    logic                 valid;
    logic                 ready;
`ifdef CNT_GATE_AUTO_RESTART_EN
    logic                 lost;

    modport master (
        output data,
        output ovf,
        output valid,
        output lost,
        input  ready
    );

    modport slave (
        input  data,
        input  ovf,
        input  valid,
        input  lost,
        output ready
    );
`else
    modport master (
        output data,
        output ovf,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  ovf,
        input  valid,
        output ready
    );
`endif
endinterface

// File: rtl/cnt_gate_ctrl.sv
// cnt_gate_ctrl - measurement-window controller for one pulse-counter channel.
//
// Sequence per measurement: IDLE -> CLEAR (counter clear pulse) -> GATE
// (counter enabled for gate_len cycles) -> SETTLE (counter idle while its
// output settles) -> CAPTURE (count, overflow flag and valid registered on the
// result bus) -> IDLE.
//
// Overflow: while the gate is open and during settle, every cycle the counter
// value is compared with the value of the previous cycle; a decrease means the
// counter wrapped and sets a sticky flag that qualifies the captured count.
//
// Optional feature macro: CNT_GATE_AUTO_RESTART_EN
//   defined   - after CAPTURE the controller re-enters CLEAR with the last
//               latched gate length (free-running windows); an unaccepted
//               result is overwritten and res.lost pulses for one cycle.
//   undefined - single-shot measurements, results are never overwritten.
module cnt_gate_ctrl #(
    parameter int CNT_WIDTH     = 8,
    parameter int GATE_WIDTH    = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [GATE_WIDTH-1:0] i_gate_len,
    input  logic [CNT_WIDTH-1:0]  i_cnt,
    output logic                  o_cnt_en,
    output logic                  o_cnt_rst,
    output logic                  o_busy,
    cnt_gate_ctrl_if.master       res
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_GATE    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    localparam logic [GATE_WIDTH-1:0] GATE_ONE   = GATE_WIDTH'(1);
    localparam logic [3:0]            SETTLE_LD  = 4'(SETTLE_CYCLES);

    state_t                state;
    logic [GATE_WIDTH-1:0] gate_len;
    logic [GATE_WIDTH-1:0] gate_tmr;
    logic [3:0]            settle_tmr;
    logic [CNT_WIDTH-1:0]  prev_cnt;
    logic                  ovf_sticky;
    logic                  start_ok;
    logic                  track_ovf;

    // A zero gate length would give an empty window; it is run as one cycle.
    function automatic logic [GATE_WIDTH-1:0] norm_len(input logic [GATE_WIDTH-1:0] len);
        norm_len = (len == '0) ? GATE_ONE : len;
    endfunction

    // A start is only honoured when the output slot is free or being freed.
    assign start_ok = i_start & (~res.valid | res.ready);

    // Wrap tracking is active while the counter may still change.
    assign track_ovf = (state == ST_GATE) || (state == ST_SETTLE);

    // Measurement sequencer: state, timers, overflow tracking and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            gate_len   <= '0;
            gate_tmr   <= '0;
            settle_tmr <= 4'd0;
            prev_cnt   <= '0;
            ovf_sticky <= 1'b0;
            o_cnt_en   <= 1'b0;
            o_cnt_rst  <= 1'b0;
            o_busy     <= 1'b0;
            res.data   <= '0;
            res.ovf    <= 1'b0;
            res.valid  <= 1'b0;
`ifdef CNT_GATE_AUTO_RESTART_EN
            res.lost   <= 1'b0;
`endif
        end else begin
            // Pulses default low; the states below raise them for one cycle.
            o_cnt_rst <= 1'b0;
`ifdef CNT_GATE_AUTO_RESTART_EN
            res.lost  <= 1'b0;
`endif

            // Consumer handshake; a capture in the same cycle overrides below.
            if (res.valid && res.ready) begin
                res.valid <= 1'b0;
            end

            // Counter wrap detection across gate and settle.
            if (track_ovf) begin
                prev_cnt <= i_cnt;
                if (i_cnt < prev_cnt) begin
                    ovf_sticky <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    o_cnt_en <= 1'b0;
                    if (start_ok) begin
                        gate_len  <= norm_len(i_gate_len);
                        o_cnt_rst <= 1'b1;
                        o_busy    <= 1'b1;
                        state     <= ST_CLEAR;
                    end else begin
                        o_busy    <= 1'b0;
                    end
                end

                ST_CLEAR: begin
                    // Counter is being cleared this cycle, so tracking restarts at 0.
                    prev_cnt   <= '0;
                    ovf_sticky <= 1'b0;
                    gate_tmr   <= gate_len;
                    o_cnt_en   <= 1'b1;
                    state      <= ST_GATE;
                end

                ST_GATE: begin
                    if (gate_tmr == GATE_ONE) begin
                        o_cnt_en   <= 1'b0;
                        settle_tmr <= SETTLE_LD;
                        state      <= ST_SETTLE;
                    end else begin
                        gate_tmr   <= gate_tmr - GATE_ONE;
                    end
                end

                ST_SETTLE: begin
                    // The first gate-closed cycle is the counter registering its
                    // last enabled increment; SETTLE_CYCLES idle cycles follow.
                    if (settle_tmr == 4'd0) begin
                        state      <= ST_CAPTURE;
                    end else begin
                        settle_tmr <= settle_tmr - 4'd1;
                    end
                end

                ST_CAPTURE: begin
                    res.data  <= i_cnt;
                    res.ovf   <= ovf_sticky;
                    res.valid <= 1'b1;
`ifdef CNT_GATE_AUTO_RESTART_EN
                    // Previous result still pending and not taken now: it is lost.
                    res.lost  <= res.valid & ~res.ready;
                    o_cnt_rst <= 1'b1;
                    state     <= ST_CLEAR;
`else
                    o_busy    <= 1'b0;
                    state     <= ST_IDLE;
`endif
                end

                default: begin
                    o_cnt_en  <= 1'b0;
                    o_busy    <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_gate_ctrl.sv
// Directed, table-driven bench for cnt_gate_ctrl with a behavioural pulse
// counter that increments once every `period` enabled cycles.
module tb_cnt_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [15:0] i_gate_len;
    logic [7:0]  cnt;
    logic        o_cnt_en;
    logic        o_cnt_rst;
    logic        o_busy;
    int          period;
    int          div;
    int          checks = 0;
    int          errors = 0;

    cnt_gate_ctrl_if #(.CNT_WIDTH(8)) res();

    cnt_gate_ctrl #(
        .CNT_WIDTH    (8),
        .GATE_WIDTH   (16),
        .SETTLE_CYCLES(2)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (i_start),
        .i_gate_len(i_gate_len),
        .i_cnt     (cnt),
        .o_cnt_en  (o_cnt_en),
        .o_cnt_rst (o_cnt_rst),
        .o_busy    (o_busy),
        .res       (res)
    );

    always #5 clk = ~clk;

    // Behavioural pulse counter: synchronous clear, counts every `period` enables.
    always @(posedge clk) begin
        if (o_cnt_rst) begin
            cnt <= 8'd0;
            div <= 0;
        end else if (o_cnt_en) begin
            if (div >= period - 1) begin
                div <= 0;
                cnt <= cnt + 8'd1;
            end else begin
                div <= div + 1;
            end
        end
    end

    typedef struct {
        logic [15:0] gl;
        int          per;
        int          exp_en;
        int          exp_lat;
        logic [7:0]  exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One measurement: start at a negedge, then count per-cycle output activity
    // from the first cycle after the accepting edge until o_valid appears.
    task automatic measure(input logic [15:0] gl, input int per, input logic rd,
                           output int rstc, output int enc, output int busyc, output int lat);
        @(negedge clk);
        period     = per;
        i_gate_len = gl;
        i_start    = 1'b1;
        res.ready  = rd;
        @(negedge clk);
        i_start    = 1'b0;
        res.ready  = 1'b0;
        i_gate_len = 16'hFFFF;
        rstc = 0; enc = 0; busyc = 0; lat = -1;
        for (int s = 0; s < 6000; s++) begin
            if (res.valid) begin
                lat = s;
                break;
            end
            rstc  += int'(o_cnt_rst);
            enc   += int'(o_cnt_en);
            busyc += int'(o_busy);
            @(negedge clk);
        end
    endtask

    task automatic accept();
        @(negedge clk);
        res.ready = 1'b1;
        @(negedge clk);
        res.ready = 1'b0;
        chk("valid_cleared_after_accept", res.valid, 0);
    endtask

    initial begin
        int rstc, enc, busyc, lat;
        int vcnt;
        vecs[0] = '{16'd100,  10, 100,  105,  8'd10,  1'b0};
        vecs[1] = '{16'd3000, 10, 3000, 3005, 8'd44,  1'b1};
        vecs[2] = '{16'd0,    1,  1,    6,    8'd1,   1'b0};
        vecs[3] = '{16'd1,    1,  1,    6,    8'd1,   1'b0};
        vecs[4] = '{16'd255,  1,  255,  260,  8'd255, 1'b0};
        vecs[5] = '{16'd256,  1,  256,  261,  8'd0,   1'b1};
        vecs[6] = '{16'd7,    3,  7,    12,   8'd2,   1'b0};

        rst        = 1'b1;
        i_start    = 1'b0;
        i_gate_len = 16'd0;
        res.ready  = 1'b0;
        period     = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and idle with no start.
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("idle_outputs", {o_cnt_en, o_cnt_rst, res.valid, res.ovf, o_busy, res.data}, 0);
        end

`ifdef CNT_GATE_AUTO_RESTART_EN
        begin
            int rst_at[$];
            int lostc;
            period     = 10;
            i_gate_len = 16'd20;
            i_start    = 1'b1;
            @(negedge clk);
            i_start    = 1'b0;
            lostc      = 0;
            for (int s = 0; s < 110; s++) begin
                if (o_cnt_rst) rst_at.push_back(s);
                lostc += int'(res.lost);
                @(negedge clk);
            end
            chk("auto_clear_pulses", rst_at.size(), 5);
            for (int k = 1; k < rst_at.size(); k++)
                chk("auto_window_spacing", rst_at[k] - rst_at[k-1], 25);
            chk("auto_lost_pulses", lostc, 3);
            chk("auto_busy", o_busy, 1);
            chk("auto_data", res.data, 2);
            res.ready = 1'b1;
            lostc     = 0;
            for (int s = 0; s < 110; s++) begin
                lostc += int'(res.lost);
                @(negedge clk);
            end
            chk("auto_no_lost_when_ready", lostc, 0);
        end
`else
        // Table-driven measurements.
        for (int i = 0; i < 7; i++) begin
            measure(vecs[i].gl, vecs[i].per, 1'b0, rstc, enc, busyc, lat);
            chk("clear_pulse_cycles", rstc, 1);
            chk("gate_enable_cycles", enc, vecs[i].exp_en);
            chk("valid_latency", lat, vecs[i].exp_lat);
            chk("busy_cycles", busyc, vecs[i].exp_lat);
            chk("busy_low_at_valid", o_busy, 0);
            chk("captured_data", res.data, vecs[i].exp_data);
            chk("captured_ovf", res.ovf, vecs[i].exp_ovf);
            accept();
        end

        // Pending result blocks a new start; start and accept in one cycle both act.
        measure(16'd5, 1, 1'b0, rstc, enc, busyc, lat);
        chk("pending_data", res.data, 5);
        vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            i_gate_len = 16'd9;
            i_start    = (c == 2) ? 1'b1 : 1'b0;
            if ({res.valid, o_busy, o_cnt_rst, res.data} == {1'b1, 1'b0, 1'b0, 8'd5}) vcnt++;
        end
        i_start = 1'b0;
        chk("pending_hold_cycles", vcnt, 20);
        measure(16'd8, 1, 1'b1, rstc, enc, busyc, lat);
        chk("restart_clear_pulse", rstc, 1);
        chk("restart_latency", lat, 13);
        chk("restart_data", res.data, 8);
        accept();

        // Reset in the middle of the gate aborts the measurement.
        @(negedge clk);
        period     = 1;
        i_gate_len = 16'd50;
        i_start    = 1'b1;
        @(negedge clk);
        i_start    = 1'b0;
        repeat (10) @(negedge clk);
        chk("gate_open_before_reset", o_cnt_en, 1);
        rst = 1'b1;
        #1;
        chk("reset_drops_enable", o_cnt_en, 0);
        chk("reset_drops_busy", o_busy, 0);
        @(negedge clk);
        rst  = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            vcnt += int'(res.valid) + int'(o_cnt_en) + int'(o_busy);
        end
        chk("no_result_after_abort", vcnt, 0);
        measure(16'd0, 1, 1'b0, rstc, enc, busyc, lat);
        chk("zero_len_enable_cycles", enc, 1);
        chk("zero_len_latency", lat, 6);
        chk("zero_len_data", res.data, 1);
        accept();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
